// File: rtl/cpu_msg_bus_arbiter.sv
// Round-robin arbiter serialising per-core START/END events onto the
// shared inter-CPU message bus, plus a running count of active cores.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clk_oe          phase strobe; index managers sample the bus when 0
//   req_start       per-core pulse: core entered START_BEGIN
//   req_end         per-core pulse: core entered FINISH_END
//   cpu_index_flat  per-core index words, core k at [k*IDX_W +: IDX_W]
//   ext_cpu_index   index of the core being broadcast
//   ext_cpu_msg     message being broadcast
//   ext_next_cpu_q  high while a broadcast is on the bus
//   bus_busy        high whenever the arbiter is not idle
//   grant           one-hot pulse when a core's event has been delivered
//   active_count    number of currently active cores
module cpu_msg_bus_arbiter #(
  parameter int N_CPU = 4,
  parameter int IDX_W = 32,
  parameter int MSG_W = 2,
  parameter logic [MSG_W-1:0] MSG_NONE  = MSG_W'(0),
  parameter logic [MSG_W-1:0] MSG_START = MSG_W'(1),
  parameter logic [MSG_W-1:0] MSG_END   = MSG_W'(2)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_oe,
  input  logic [N_CPU-1:0]           req_start,
  input  logic [N_CPU-1:0]           req_end,
  input  logic [N_CPU*IDX_W-1:0]     cpu_index_flat,
  output logic [IDX_W-1:0]           ext_cpu_index,
  output logic [MSG_W-1:0]           ext_cpu_msg,
  output logic                       ext_next_cpu_q,
  output logic                       bus_busy,
  output logic [N_CPU-1:0]           grant,
  output logic [$clog2(N_CPU+1)-1:0] active_count
);

  localparam int PW = $clog2(N_CPU);
  localparam int CW = $clog2(N_CPU+1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_CPU-1:0]  pst_q, pst_d;
  logic [N_CPU-1:0]  pen_q, pen_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     win_q, win_d;
  logic              win_end_q, win_end_d;
  logic              seen_q, seen_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic              nq_q, nq_d;
  logic [N_CPU-1:0]  grant_q, grant_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [N_CPU-1:0]  clr_s, clr_e;
  logic [N_CPU-1:0]  win_oh;
  logic [IDX_W-1:0]  idx_arr [N_CPU];

  for (genvar k = 0; k < N_CPU; k++) begin : g_idx
    assign idx_arr[k] = cpu_index_flat[k*IDX_W +: IDX_W];
  end

  assign win_oh = {{(N_CPU-1){1'b0}}, 1'b1} << win_q;

  // Rotating search starting at rr_q; first core with any pending bit wins.
  logic          found;
  logic [PW-1:0] pick;
  logic [PW:0]   jj;
  logic [PW-1:0] j;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    jj    = '0;
    j     = '0;
    for (int i = 0; i < N_CPU; i++) begin
      jj = {1'b0, rr_q} + (PW+1)'(i);
      if (jj >= (PW+1)'(N_CPU)) begin
        jj = jj - (PW+1)'(N_CPU);
      end
      j = jj[PW-1:0];
      if (!found && (pst_q[j] || pen_q[j])) begin
        found = 1'b1;
        pick  = j;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    win_end_d = win_end_q;
    seen_d    = seen_q;
    idx_d     = idx_q;
    msg_d     = msg_q;
    nq_d      = nq_q;
    grant_d   = '0;
    cnt_d     = cnt_q;
    clr_s     = '0;
    clr_e     = '0;
    case (state_q)
      S_IDLE: begin
        if (clk_oe && found) begin
          state_d   = S_DRIVE;
          win_d     = pick;
          win_end_d = pen_q[pick];
          idx_d     = idx_arr[pick];
          msg_d     = pen_q[pick] ? MSG_END : MSG_START;
          nq_d      = 1'b1;
          seen_d    = 1'b0;
        end
      end
      S_DRIVE: begin
        // Leave only after a full clk_oe==0 cycle has been on the bus.
        if (seen_q) begin
          state_d = S_RELEASE;
          idx_d   = '0;
          msg_d   = MSG_NONE;
          nq_d    = 1'b0;
          grant_d = win_oh;
        end else if (!clk_oe) begin
          seen_d = 1'b1;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        rr_d    = (win_q == PW'(N_CPU-1)) ? '0 : win_q + PW'(1);
        if (win_end_q) begin
          clr_e = win_oh;
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end else begin
          clr_s = win_oh;
          if (cnt_q < CW'(N_CPU)) cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new pulse landing on a bit being cleared keeps it pending.
    pst_d = (pst_q & ~clr_s) | req_start;
    pen_d = (pen_q & ~clr_e) | req_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pst_q     <= '0;
      pen_q     <= '0;
      rr_q      <= '0;
      win_q     <= '0;
      win_end_q <= 1'b0;
      seen_q    <= 1'b0;
      idx_q     <= '0;
      msg_q     <= MSG_NONE;
      nq_q      <= 1'b0;
      grant_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pst_q     <= pst_d;
      pen_q     <= pen_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      win_end_q <= win_end_d;
      seen_q    <= seen_d;
      idx_q     <= idx_d;
      msg_q     <= msg_d;
      nq_q      <= nq_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ext_cpu_index  = idx_q;
  assign ext_cpu_msg    = msg_q;
  assign ext_next_cpu_q = nq_q;
  assign bus_busy       = (state_q != S_IDLE);
  assign grant          = grant_q;
  assign active_count   = cnt_q;

endmodule

// File: tb/tb_cpu_msg_bus_arbiter.sv
// Bench for cpu_msg_bus_arbiter: directed scenarios plus random bursts
// checked against a transaction-level model of pending events.
module tb_cpu_msg_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         clk_oe;
  logic [3:0]   req_start;
  logic [3:0]   req_end;
  logic [127:0] cpu_index_flat;
  logic [31:0]  ext_cpu_index;
  logic [1:0]   ext_cpu_msg;
  logic         ext_next_cpu_q;
  logic         bus_busy;
  logic [3:0]   grant;
  logic [2:0]   active_count;

  logic [31:0] idx_val [4];

  for (genvar k = 0; k < 4; k++) begin : g_pack
    assign cpu_index_flat[k*32 +: 32] = idx_val[k];
  end

  cpu_msg_bus_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .clk_oe         (clk_oe),
    .req_start      (req_start),
    .req_end        (req_end),
    .cpu_index_flat (cpu_index_flat),
    .ext_cpu_index  (ext_cpu_index),
    .ext_cpu_msg    (ext_cpu_msg),
    .ext_next_cpu_q (ext_next_cpu_q),
    .bus_busy       (bus_busy),
    .grant          (grant),
    .active_count   (active_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int oe_mode = 0;

  bit m_ps [4];
  bit m_pe [4];
  int m_rr;
  int m_cnt;

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_ps[i] = 0;
      m_pe[i] = 0;
    end
    m_rr  = 0;
    m_cnt = 0;
  endfunction

  function automatic int m_pick();
    int c;
    for (int i = 0; i < 4; i++) begin
      c = (m_rr + i) % 4;
      if (m_ps[c] || m_pe[c]) return c;
    end
    return -1;
  endfunction

  function automatic void m_serve(input int w);
    if (m_pe[w]) begin
      m_pe[w] = 0;
      if (m_cnt > 0) m_cnt--;
    end else begin
      m_ps[w] = 0;
      if (m_cnt < 4) m_cnt++;
    end
    m_rr = (w + 1) % 4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    case (oe_mode)
      0: clk_oe = ~clk_oe;
      1: clk_oe = 1'($urandom);
      default: ;
    endcase
  endtask

  task automatic pulse(input logic [3:0] rs, input logic [3:0] re);
    req_start = rs;
    req_end   = re;
    for (int i = 0; i < 4; i++) begin
      if (rs[i]) m_ps[i] = 1;
      if (re[i]) m_pe[i] = 1;
    end
    step();
    req_start = '0;
    req_end   = '0;
  endtask

  task automatic wait_bus(output bit to);
    to = 1;
    for (int i = 0; i < 40; i++) begin
      if (to) begin
        if (ext_next_cpu_q === 1'b1) to = 0;
        else step();
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_start = '0;
    req_end = '0;
    step();
    step();
    rst = 1'b0;
    m_reset();
  endtask

  // Serve everything the model holds, checking each broadcast.
  task automatic drain(input string tag, input bit repulse);
    int w, d, fl, guard;
    logic [31:0] ei;
    logic [1:0] em;
    bit to;
    guard = 0;
    while (m_pick() >= 0 && guard < 40) begin
      guard++;
      w  = m_pick();
      em = m_pe[w] ? 2'd2 : 2'd1;
      ei = idx_val[w];
      wait_bus(to);
      vectors++;
      if (to) begin
        miscompares++;
        $display("FAIL %s bus_timeout: no broadcast for core %0d", tag, w);
        return;
      end
      d  = 0;
      fl = -1;
      while (grant == 4'b0 && d < 60) begin
        vectors++;
        if (ext_next_cpu_q !== 1'b1 || bus_busy !== 1'b1 ||
            ext_cpu_index !== ei || ext_cpu_msg !== em) begin
          miscompares++;
          $display("FAIL %s drive core%0d: got q=%b idx=%h msg=%0d exp q=1 idx=%h msg=%0d",
                   tag, w, ext_next_cpu_q, ext_cpu_index, ext_cpu_msg, ei, em);
        end
        if (fl < 0 && clk_oe == 1'b0) fl = d;
        step();
        d++;
      end
      vectors++;
      if (grant !== (4'b0001 << w) || ext_next_cpu_q !== 1'b0 ||
          ext_cpu_msg !== 2'd0 || ext_cpu_index !== 32'd0) begin
        miscompares++;
        $display("FAIL %s release: got grant=%b q=%b msg=%0d idx=%h exp grant=%b idle bus",
                 tag, grant, ext_next_cpu_q, ext_cpu_msg, ext_cpu_index, 4'b0001 << w);
      end
      vectors++;
      if (fl < 0 || d != fl + 2) begin
        miscompares++;
        $display("FAIL %s drive_len: got %0d cycles, first oe low at %0d", tag, d, fl);
      end
      m_serve(w);
      if (repulse && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          req_start[w] = 1'b1;
          m_ps[w] = 1;
        end else begin
          req_end[w] = 1'b1;
          m_pe[w] = 1;
        end
      end
      step();
      req_start = '0;
      req_end   = '0;
      vectors++;
      if (active_count !== 3'(m_cnt) || grant !== 4'b0) begin
        miscompares++;
        $display("FAIL %s count: got cnt=%0d grant=%b exp cnt=%0d grant=0",
                 tag, active_count, grant, m_cnt);
      end
    end
  endtask

  always @(negedge clk) begin
    vectors++;
    if ((|grant && ext_next_cpu_q) || $countones(grant) > 1) begin
      miscompares++;
      $display("FAIL overlap: grant=%b next_q=%b", grant, ext_next_cpu_q);
    end
  end

  task automatic test_reset();
    do_reset();
    vectors++;
    if (ext_cpu_index !== 32'd0 || ext_cpu_msg !== 2'd0 ||
        ext_next_cpu_q !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bus: got idx=%h msg=%0d q=%b exp 0/0/0",
               ext_cpu_index, ext_cpu_msg, ext_next_cpu_q);
    end
    vectors++;
    if (bus_busy !== 1'b0 || grant !== 4'b0 || active_count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_ctl: got busy=%b grant=%b cnt=%0d exp 0/0/0",
               bus_busy, grant, active_count);
    end
  endtask

  task automatic test_single_start();
    pulse(4'b0100, 4'b0000);
    drain("single_start", 0);
    vectors++;
    if (active_count !== 3'd1) begin
      miscompares++;
      $display("FAIL single_cnt: got %0d exp 1", active_count);
    end
  endtask

  task automatic test_multi_start();
    do_reset();
    pulse(4'b1011, 4'b0000);
    drain("multi_start", 0);
    vectors++;
    if (active_count !== 3'd3) begin
      miscompares++;
      $display("FAIL multi_cnt: got %0d exp 3", active_count);
    end
  endtask

  task automatic test_both_pending();
    pulse(4'b0010, 4'b0010);
    drain("both_pending", 0);
  endtask

  task automatic test_end_saturation();
    do_reset();
    pulse(4'b0000, 4'b0001);
    drain("end_sat", 0);
    vectors++;
    if (active_count !== 3'd0) begin
      miscompares++;
      $display("FAIL end_sat_cnt: got %0d exp 0", active_count);
    end
  endtask

  task automatic test_reset_mid_drive();
    bit to;
    pulse(4'b0010, 4'b0000);
    wait_bus(to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL rst_mid_wait: got no broadcast exp one");
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_reset();
    vectors++;
    if (ext_next_cpu_q !== 1'b0 || ext_cpu_msg !== 2'd0 ||
        bus_busy !== 1'b0 || grant !== 4'b0 || active_count !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_mid: got q=%b msg=%0d busy=%b grant=%b cnt=%0d exp idle",
               ext_next_cpu_q, ext_cpu_msg, bus_busy, grant, active_count);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (bus_busy !== 1'b0 || grant !== 4'b0) begin
        miscompares++;
        $display("FAIL rst_mid_pending: got busy=%b grant=%b exp 0/0",
                 bus_busy, grant);
      end
    end
    pulse(4'b1000, 4'b0000);
    drain("after_rst", 0);
  endtask

  task automatic test_hold_oe();
    bit to;
    logic [31:0] ei;
    oe_mode = 2;
    clk_oe = 1'b1;
    ei = idx_val[m_pick() < 0 ? m_rr : m_rr];
    pulse(4'b0001, 4'b0000);
    ei = idx_val[0];
    wait_bus(to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL hold_wait: got no broadcast exp one");
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (ext_next_cpu_q !== 1'b1 || ext_cpu_index !== ei ||
          ext_cpu_msg !== 2'd1 || grant !== 4'b0) begin
        miscompares++;
        $display("FAIL hold_stable: got q=%b idx=%h msg=%0d grant=%b exp 1/%h/1/0",
                 ext_next_cpu_q, ext_cpu_index, ext_cpu_msg, grant, ei);
      end
      step();
    end
    clk_oe = 1'b0;
    step();
    clk_oe = 1'b1;
    vectors++;
    if (ext_next_cpu_q !== 1'b1 || grant !== 4'b0) begin
      miscompares++;
      $display("FAIL hold_after_low: got q=%b grant=%b exp 1/0",
               ext_next_cpu_q, grant);
    end
    step();
    m_serve(0);
    vectors++;
    if (grant !== 4'b0001 || ext_next_cpu_q !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_grant: got grant=%b q=%b exp 0001/0",
               grant, ext_next_cpu_q);
    end
    step();
    vectors++;
    if (active_count !== 3'(m_cnt)) begin
      miscompares++;
      $display("FAIL hold_cnt: got %0d exp %0d", active_count, m_cnt);
    end
    oe_mode = 0;
  endtask

  task automatic test_random();
    int nb;
    logic [3:0] rs, re;
    for (int b = 0; b < 30; b++) begin
      for (int k = 0; k < 4; k++) idx_val[k] = $urandom;
      oe_mode = 2;
      clk_oe = 1'b0;
      nb = $urandom_range(1, 3);
      for (int p = 0; p < nb; p++) begin
        rs = 4'($urandom);
        re = 4'($urandom) & 4'($urandom);
        pulse(rs, re);
      end
      oe_mode = 1;
      drain("random", 1);
      for (int i = 0; i < 3; i++) begin
        step();
        vectors++;
        if (bus_busy !== 1'b0) begin
          miscompares++;
          $display("FAIL random_idle: got busy=%b exp 0", bus_busy);
        end
      end
    end
    oe_mode = 0;
  endtask

  initial begin
    rst = 1'b1;
    clk_oe = 1'b1;
    req_start = '0;
    req_end = '0;
    idx_val[0] = 32'h8000_0011;
    idx_val[1] = 32'h0000_2222;
    idx_val[2] = 32'h8000_3333;
    idx_val[3] = 32'h1234_5678;
    m_reset();
    test_reset();
    test_single_start();
    test_multi_start();
    test_both_pending();
    test_end_saturation();
    test_reset_mid_drive();
    test_hold_oe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
